// File: rtl/rr_arb16_dec.sv
// Round-robin arbiter over 16 requesters with a registered owner index and a
// one-hot decoded grant vector for the shared resource's select lines.

module rr_arb16_dec_lane #(
    parameter int LANE = 0
) (
    input  logic [3:0] idx,
    input  logic       vld,
    output logic       gnt
);
    assign gnt = vld && (idx == 4'(LANE));
endmodule

module rr_arb16_dec #(
    parameter int MAX_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_vld,
    output logic        preempt
);
    localparam int NUM_LANES = 16;
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [3:0] ptr_q, ptr_d, idx_q, idx_d;
    logic       vld_q, vld_d, pre_q, pre_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] pick;
    logic       rel_to, rel_req, release_now;

    // Scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        pick = ptr_q;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req[ptr_q + 4'(i)]) pick = ptr_q + 4'(i);
        end
    end

    assign rel_to      = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign rel_req     = !req[idx_q];
    assign release_now = done || rel_req || rel_to;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    idx_d   = pick;
                    vld_d   = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 4'd1;
                    pre_d   = rel_to && !done && !rel_req;
                    state_d = IDLE;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
        end
    end

    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign preempt = pre_q;

    // Select-line decode: one lane per requester, driven only by registers.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        rr_arb16_dec_lane #(.LANE(k)) u_lane (.idx(idx_q), .vld(vld_q), .gnt(gnt[k]));
    end
endmodule
